commit_controller: RTL and testbench
====================================

Name: commit_controller

Overview:
- Sequences in-order retirement from the ROB head into the register file's commit port and its rollback input.
- Retires at most one entry per cycle.
- Holds store retirement until the load/store buffer confirms the write.
- On a mispredicted branch, issues the register-file rollback, the PC redirect and a fixed flush window.

Parameters:
ROB_ID_W, 4, ROB tag width; tag 0 is ZERO_ROB (no entry)
FLUSH_CYCLES, 2, cycles of commit blackout after rollback; legal values >= 1
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rdy  in  1  global ready; low freezes the block
head_valid  in  1  ROB head slot occupied
head_ready  in  1  head result available
head_rob_id  in  ROB_ID_W  head tag (nonzero)
head_type  in  2  0=ALU, 1=STORE, 2=BRANCH, 3=HALT
head_rd  in  5  destination register
head_value  in  32  result value
head_mispredict  in  1  branch resolved wrong (valid when head_type=BRANCH)
head_target_pc  in  32  correct PC for a mispredict
commit_pop  out  1  combinational; ROB advances head at this edge
store_req  out  1  request LSB to perform head store
store_rob_id  out  ROB_ID_W  tag of requested store
store_done  in  1  LSB store finished
commit_flag  out  1  register-file write strobe
commit_rd  out  5  register-file rd
commit_q  out  ROB_ID_W  tag for Q-elimination compare
commit_v  out  32  write data
rollback_flag  out  1  clear all Q tags
redirect_valid  out  1  fetch redirect pulse
redirect_pc  out  32  redirect target
halt_out  out  1  sticky halt
retired_cnt  out  CNT_W  retired-entry count

Behaviour:
- Reset (rst_n=0, async):
  - State = RUN.
  - All outputs are 0; retired_cnt = 0; flush counter = 0.
  - Reset during WAIT_STORE or FLUSH abandons that state; store_req drops immediately.
- rdy=0:
  - No state, counter or register update.
  - commit_pop = 0.
  - At the next edge, the pulse outputs (commit_flag, rollback_flag, redirect_valid) register 0.
  - store_req and halt_out hold their values.
- Timing:
  - commit_pop is combinational in the accepting cycle.
  - commit_flag, commit_rd, commit_q, commit_v, rollback_flag, redirect_valid and redirect_pc register at that edge. Register-file latency is 1 cycle.
  - Each pulse lasts exactly 1 cycle unless the next entry is accepted.
- State RUN: accept only when head_valid && head_ready && rdy. Otherwise stall with no pulses.
  - ALU, or BRANCH with no mispredict:
    - commit_pop=1.
    - Next cycle: commit_flag=1, commit_rd=head_rd, commit_q=head_rob_id, commit_v=head_value.
    - head_rd=0 still pulses commit_flag; the register file ignores x0.
    - Back-to-back accepts give 1 commit/cycle.
  - STORE:
    - No pop.
    - store_req=1 and store_rob_id=head_rob_id, registered.
    - Go to WAIT_STORE.
  - BRANCH with mispredict:
    - commit_pop=1.
    - Next cycle: commit_flag=1 with rd/q/v as above (link write), rollback_flag=1, redirect_valid=1, redirect_pc=head_target_pc.
    - The commit and the rollback occur in the same cycle; the register file writes V and clears all Q.
    - Flush counter = FLUSH_CYCLES-1; go to FLUSH.
  - HALT:
    - commit_pop=1; halt_out=1 (sticky); go to HALTED.
    - No commit_flag.
- WAIT_STORE:
  - Hold store_req until store_done && rdy.
  - In that cycle: commit_pop=1; store_req clears at the edge; return to RUN.
  - No register-file pulse.
  - A new head is not examined in the same cycle.
- FLUSH:
  - No pops.
  - Counter decrements each rdy cycle; at 0, go to RUN.
  - Blackout lasts exactly FLUSH_CYCLES cycles after the rollback edge.
- HALTED: no pops or pulses until reset.
- store_done outside WAIT_STORE is ignored.
- retired_cnt increments by 1 on every commit_pop and wraps modulo 2^CNT_W.
- head_mispredict is ignored for non-BRANCH types.

Decomposition:
- constant.v gains:
  - COMMIT_TYPE_ALU/STORE/BRANCH/HALT encodings and a COMMIT_TYPE_TYPE width macro.
  - FSM state encodings.
- The block reuses the existing ROB_ID_TYPE, REG_POS_TYPE, DATA_TYPE and ZERO_ROB macros.
- Single module; no sub-module (the FSM and flush counter are small).

Test Plan:
- Three back-to-back ALU heads (ids 1,2,3; rd 5,6,7; values 0x11,0x22,0x33) -> commit_pop high 3 consecutive cycles; commit_flag high 3 cycles one cycle later with matching rd/q/v; retired_cnt=3.
- STORE head id 4 with store_done after 5 cycles -> store_req=1 and store_rob_id=4 for 5 cycles; one pop in the store_done cycle; no commit_flag.
- Mispredict BRANCH id 9, rd 1, value 0x104, target 0x200, FLUSH_CYCLES=2 -> next cycle commit_flag, rollback_flag and redirect_valid all =1 with redirect_pc=0x200; then 2 cycles with no pop despite a ready head; resume in the 3rd cycle.
- rdy low for 3 cycles with a ready ALU head -> no pop or pulses; commit occurs one cycle after rdy returns.
- Assert rst_n low mid-WAIT_STORE -> store_req drops asynchronously; after release, state is RUN and retired_cnt=0.
- HALT head -> one pop, halt_out=1; later ready heads are never popped.

Source files
------------

// File: rtl/commit_controller_pkg.sv
// -----------------------------------------------------------------------------
// commit_controller_pkg
//
// Purpose:
//   Shared encodings for the in-order commit controller: the ROB head entry
//   type codes, the controller FSM states, and the data/register widths the
//   commit port uses toward the register file.
//
// Contents:
//   DATA_W / REG_W / COMMIT_TYPE_W  - datapath widths of the commit port
//   ZERO_ROB_ID                     - tag value meaning "no entry"
//   commit_type_e                   - ALU / STORE / BRANCH / HALT head types
//   commit_state_e                  - RUN / WAIT_STORE / FLUSH / HALTED
//   writes_regfile()                - which head types produce an RF write
// -----------------------------------------------------------------------------
package commit_controller_pkg;

  localparam int DATA_W        = 32;
  localparam int REG_W         = 5;
  localparam int COMMIT_TYPE_W = 2;

  // Tag 0 never names a live ROB entry, so consumers of commit_q can use it
  // as the "no producer" value when they compare against their Q tags.
  localparam int ZERO_ROB_ID = 0;

  typedef enum logic [COMMIT_TYPE_W-1:0] {
    COMMIT_TYPE_ALU    = 2'd0,
    COMMIT_TYPE_STORE  = 2'd1,
    COMMIT_TYPE_BRANCH = 2'd2,
    COMMIT_TYPE_HALT   = 2'd3
  } commit_type_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_STORE = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_HALTED     = 2'd3
  } commit_state_e;

  // ALU results and branch link values both land in the register file;
  // stores and halts never write a destination register.
  function automatic logic writes_regfile(input commit_type_e kind);
    return (kind == COMMIT_TYPE_ALU) || (kind == COMMIT_TYPE_BRANCH);
  endfunction

endpackage

// File: rtl/commit_controller.sv
// -----------------------------------------------------------------------------
// commit_controller
//
// Purpose:
//   Retires the ROB head in program order, at most one entry per cycle.
//   ALU and branch results are forwarded to the register file commit port one
//   cycle after the ROB is told to pop. Stores are handed to the load/store
//   buffer and the head is only popped once the buffer confirms the write.
//   A mispredicted branch commits its link value, clears every Q tag in the
//   register file, redirects fetch and then blacks out commit for a fixed
//   number of cycles while the front end refills. A HALT entry stops the
//   controller until reset.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rdy                   global ready; low freezes all state
//   head_*                ROB head slot: valid, ready, tag, type, rd, value,
//                         mispredict flag and correct target PC
//   commit_pop            combinational; ROB advances its head at this edge
//   store_req/_rob_id     registered store request toward the LSB
//   store_done            LSB completion of the requested store
//   commit_flag/rd/q/v    registered register-file write strobe and payload
//   rollback_flag         registered pulse clearing all register Q tags
//   redirect_valid/_pc    registered fetch redirect pulse and target
//   halt_out              sticky halt indication
//   retired_cnt           number of entries popped, wraps
// -----------------------------------------------------------------------------
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int ROB_ID_W     = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,

  input  logic                 head_valid,
  input  logic                 head_ready,
  input  logic [ROB_ID_W-1:0]  head_rob_id,
  input  logic [1:0]           head_type,
  input  logic [REG_W-1:0]     head_rd,
  input  logic [DATA_W-1:0]    head_value,
  input  logic                 head_mispredict,
  input  logic [DATA_W-1:0]    head_target_pc,

  output logic                 commit_pop,

  output logic                 store_req,
  output logic [ROB_ID_W-1:0]  store_rob_id,
  input  logic                 store_done,

  output logic                 commit_flag,
  output logic [REG_W-1:0]     commit_rd,
  output logic [ROB_ID_W-1:0]  commit_q,
  output logic [DATA_W-1:0]    commit_v,

  output logic                 rollback_flag,
  output logic                 redirect_valid,
  output logic [DATA_W-1:0]    redirect_pc,

  output logic                 halt_out,
  output logic [CNT_W-1:0]     retired_cnt
);

  // The flush counter only needs to hold FLUSH_CYCLES-1; keep at least one
  // bit so a single-cycle blackout still has a legal vector.
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

  commit_state_e       state;
  commit_state_e       state_nxt;
  logic [FLUSH_W-1:0]  flush_cnt;
  logic [FLUSH_W-1:0]  flush_cnt_nxt;

  commit_type_e        head_kind;

  logic                take_reg;
  logic                take_store;
  logic                take_mispredict;
  logic                take_halt;
  logic                store_finish;

  assign head_kind = commit_type_e'(head_type);

  // State register. Reset abandons WAIT_STORE or FLUSH outright; nothing is
  // replayed, the ROB is expected to be reset alongside this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Next-state and accept decode. Every decision is qualified by rdy, so a
  // frozen cycle leaves the state and counter untouched and raises no pop.
  // The take_* strobes tell the output registers what was accepted this
  // cycle; they are all zero whenever rdy is low.
  // In WAIT_STORE the completing cycle only pops the store; the next head is
  // looked at one cycle later from RUN, which keeps the one-pop-per-cycle
  // guarantee simple.
  // The flush counter is loaded with FLUSH_CYCLES-1 on the rollback edge and
  // the return to RUN happens on the edge where it is already zero, giving a
  // blackout of exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_nxt       = state;
    flush_cnt_nxt   = flush_cnt;
    commit_pop      = 1'b0;
    take_reg        = 1'b0;
    take_store      = 1'b0;
    take_mispredict = 1'b0;
    take_halt       = 1'b0;
    store_finish    = 1'b0;

    if (rdy) begin
      case (state)
        ST_RUN: begin
          if (head_valid && head_ready) begin
            case (head_kind)
              COMMIT_TYPE_ALU: begin
                commit_pop = 1'b1;
                take_reg   = 1'b1;
              end
              COMMIT_TYPE_BRANCH: begin
                commit_pop = 1'b1;
                take_reg   = 1'b1;
                if (head_mispredict) begin
                  take_mispredict = 1'b1;
                  flush_cnt_nxt   = FLUSH_LOAD;
                  state_nxt       = ST_FLUSH;
                end
              end
              COMMIT_TYPE_STORE: begin
                take_store = 1'b1;
                state_nxt  = ST_WAIT_STORE;
              end
              COMMIT_TYPE_HALT: begin
                commit_pop = 1'b1;
                take_halt  = 1'b1;
                state_nxt  = ST_HALTED;
              end
              default: begin
                state_nxt = ST_RUN;
              end
            endcase
          end
        end

        ST_WAIT_STORE: begin
          if (store_done) begin
            commit_pop   = 1'b1;
            store_finish = 1'b1;
            state_nxt    = ST_RUN;
          end
        end

        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - FLUSH_W'(1);
          end
        end

        ST_HALTED: begin
          state_nxt = ST_HALTED;
        end

        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Register-file commit port. The strobe is re-evaluated every edge, so it
  // is a one-cycle pulse unless the next head is accepted straight away; a
  // frozen cycle registers zero because take_reg is gated by rdy. The payload
  // only moves on an accept, which keeps it stable for anyone sampling late.
  // Writes to x0 are still strobed; the register file discards them itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_flag <= 1'b0;
      commit_rd   <= '0;
      commit_q    <= '0;
      commit_v    <= '0;
    end else begin
      commit_flag <= take_reg;
      if (take_reg) begin
        commit_rd <= head_rd;
        commit_q  <= head_rob_id;
        commit_v  <= head_value;
      end
    end
  end

  // Mispredict recovery. The rollback and redirect pulses share the edge of
  // the branch's own link commit, so the register file sees the write and the
  // Q-tag clear together and the link value is not lost to the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rollback_flag  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      rollback_flag  <= take_mispredict;
      redirect_valid <= take_mispredict;
      if (take_mispredict) begin
        redirect_pc <= head_target_pc;
      end
    end
  end

  // Store handshake with the LSB. The request is a level that stays up for
  // the whole WAIT_STORE residency, including frozen cycles, and drops on the
  // edge where the completion is taken. Reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_req    <= 1'b0;
      store_rob_id <= '0;
    end else if (take_store) begin
      store_req    <= 1'b1;
      store_rob_id <= head_rob_id;
    end else if (store_finish) begin
      store_req    <= 1'b0;
    end
  end

  // Sticky halt flag and the retired-entry counter. The counter follows
  // commit_pop exactly, so stores count when they finally pop and halts
  // count once; it wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_out    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (take_halt) begin
        halt_out <= 1'b1;
      end
      if (commit_pop) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_controller.sv
// -----------------------------------------------------------------------------
// tb_commit_controller
//
// Directed bench for commit_controller. Expected register-file commits are
// pushed into a scoreboard queue when the accepting head is driven; a monitor
// pops one record for every commit/rollback/redirect pulse the DUT shows.
// Cycle-level behaviour (pop, store handshake, halt, counter) is checked
// inline against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_commit_controller;
  import commit_controller_pkg::*;

  localparam int ROB_ID_W     = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic                clk;
  logic                rst_n;
  logic                rdy;
  logic                head_valid;
  logic                head_ready;
  logic [ROB_ID_W-1:0] head_rob_id;
  logic [1:0]          head_type;
  logic [4:0]          head_rd;
  logic [31:0]         head_value;
  logic                head_mispredict;
  logic [31:0]         head_target_pc;
  logic                commit_pop;
  logic                store_req;
  logic [ROB_ID_W-1:0] store_rob_id;
  logic                store_done;
  logic                commit_flag;
  logic [4:0]          commit_rd;
  logic [ROB_ID_W-1:0] commit_q;
  logic [31:0]         commit_v;
  logic                rollback_flag;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;
  logic                halt_out;
  logic [CNT_W-1:0]    retired_cnt;

  typedef struct packed {
    logic [4:0]          rd;
    logic [ROB_ID_W-1:0] q;
    logic [31:0]         v;
    logic                rb;
    logic                rv;
    logic [31:0]         pc;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;

  commit_controller #(
    .ROB_ID_W     (ROB_ID_W),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .head_valid      (head_valid),
    .head_ready      (head_ready),
    .head_rob_id     (head_rob_id),
    .head_type       (head_type),
    .head_rd         (head_rd),
    .head_value      (head_value),
    .head_mispredict (head_mispredict),
    .head_target_pc  (head_target_pc),
    .commit_pop      (commit_pop),
    .store_req       (store_req),
    .store_rob_id    (store_rob_id),
    .store_done      (store_done),
    .commit_flag     (commit_flag),
    .commit_rd       (commit_rd),
    .commit_q        (commit_q),
    .commit_v        (commit_v),
    .rollback_flag   (rollback_flag),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt_out        (halt_out),
    .retired_cnt     (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdyV, input logic valid, input logic ready,
                               input logic [1:0] kind, input logic [3:0] id,
                               input logic [4:0] rd, input logic [31:0] value,
                               input logic mis, input logic [31:0] target,
                               input logic sdone);
    rdy             = rdyV;
    head_valid      = valid;
    head_ready      = ready;
    head_type       = kind;
    head_rob_id     = id;
    head_rd         = rd;
    head_value      = value;
    head_mispredict = mis;
    head_target_pc  = target;
    store_done      = sdone;
  endtask

  task automatic idle(input logic sdone);
    applyStimulus(1'b1, 1'b0, 1'b0, COMMIT_TYPE_ALU, 4'd0, 5'd0, 32'd0, 1'b0, 32'd0, sdone);
  endtask

  task automatic pushExp(input logic [4:0] rd, input logic [3:0] q, input logic [31:0] v,
                         input logic rb, input logic rv, input logic [31:0] pc);
    exp_t e;
    e.rd = rd; e.q = q; e.v = v; e.rb = rb; e.rv = rv; e.pc = pc;
    expQ.push_back(e);
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every visible pulse consumes one expected record.
  always @(negedge clk) begin
    if (rst_n && (commit_flag || rollback_flag || redirect_valid)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected_pulse: actual flag=%b rb=%b rv=%b required no pulse",
                 commit_flag, rollback_flag, redirect_valid);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sb_commit_flag", 32'(commit_flag), 32'd1);
        checkOutput("sb_commit_rd", 32'(commit_rd), 32'(monExp.rd));
        checkOutput("sb_commit_q", 32'(commit_q), 32'(monExp.q));
        checkOutput("sb_commit_v", commit_v, monExp.v);
        checkOutput("sb_rollback", 32'(rollback_flag), 32'(monExp.rb));
        checkOutput("sb_redirect_valid", 32'(redirect_valid), 32'(monExp.rv));
        if (monExp.rv) checkOutput("sb_redirect_pc", redirect_pc, monExp.pc);
      end
    end
  end

  logic [3:0]  aluId  [3] = '{4'd1, 4'd2, 4'd3};
  logic [4:0]  aluRd  [3] = '{5'd5, 5'd6, 5'd7};
  logic [31:0] aluVal [3] = '{32'h11, 32'h22, 32'h33};

  initial begin
    rst_n = 1'b1;
    idle(1'b0);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_commit_pop", 32'(commit_pop), 32'd0);
    checkOutput("rst_store_req", 32'(store_req), 32'd0);
    checkOutput("rst_commit_flag", 32'(commit_flag), 32'd0);
    checkOutput("rst_rollback", 32'(rollback_flag), 32'd0);
    checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("rst_halt", 32'(halt_out), 32'd0);
    checkOutput("rst_retired_cnt", retired_cnt, 32'd0);
    checkOutput("rst_commit_v", commit_v, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    endCycle();

    // Head present but result not ready: stall.
    applyStimulus(1'b1, 1'b1, 1'b0, COMMIT_TYPE_ALU, 4'd1, 5'd5, 32'h11, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("notready_pop", 32'(commit_pop), 32'd0);
    endCycle();

    // Three back-to-back ALU retirements.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_ALU, aluId[i], aluRd[i], aluVal[i],
                    1'b0, 32'd0, 1'b0);
      pushExp(aluRd[i], aluId[i], aluVal[i], 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      checkOutput("alu_pop", 32'(commit_pop), 32'd1);
      endCycle();
    end
    idle(1'b0);
    @(negedge clk);
    checkOutput("alu_idle_pop", 32'(commit_pop), 32'd0);
    checkOutput("alu_retired_cnt", retired_cnt, 32'd3);
    endCycle();
    idle(1'b0);
    @(negedge clk);
    checkOutput("alu_pulse_end", 32'(commit_flag), 32'd0);
    endCycle();

    // Store id 4, LSB completes after five request cycles.
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_STORE, 4'd4, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("store_accept_pop", 32'(commit_pop), 32'd0);
    endCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_STORE, 4'd4, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("store_req_hold", 32'(store_req), 32'd1);
      checkOutput("store_rob_id", 32'(store_rob_id), 32'd4);
      checkOutput("store_wait_pop", 32'(commit_pop), 32'd0);
      endCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_STORE, 4'd4, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("store_done_req", 32'(store_req), 32'd1);
    checkOutput("store_done_pop", 32'(commit_pop), 32'd1);
    endCycle();
    idle(1'b1);
    @(negedge clk);
    checkOutput("store_req_clear", 32'(store_req), 32'd0);
    checkOutput("store_stray_done_pop", 32'(commit_pop), 32'd0);
    checkOutput("store_retired_cnt", retired_cnt, 32'd4);
    endCycle();

    // Mispredicted branch then a two-cycle blackout.
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_BRANCH, 4'd9, 5'd1, 32'h104, 1'b1, 32'h200, 1'b0);
    pushExp(5'd1, 4'd9, 32'h104, 1'b1, 1'b1, 32'h200);
    @(negedge clk);
    checkOutput("br_pop", 32'(commit_pop), 32'd1);
    endCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_ALU, 4'd10, 5'd2, 32'h55, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("flush1_pop", 32'(commit_pop), 32'd0);
    checkOutput("br_rollback", 32'(rollback_flag), 32'd1);
    checkOutput("br_redirect_pc", redirect_pc, 32'h200);
    endCycle();
    @(negedge clk);
    checkOutput("flush2_pop", 32'(commit_pop), 32'd0);
    checkOutput("flush2_rollback", 32'(rollback_flag), 32'd0);
    endCycle();
    pushExp(5'd2, 4'd10, 32'h55, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("flush_resume_pop", 32'(commit_pop), 32'd1);
    endCycle();
    idle(1'b0);
    @(negedge clk);
    checkOutput("br_retired_cnt", retired_cnt, 32'd6);
    endCycle();

    // rdy low for three cycles with a ready ALU head.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, COMMIT_TYPE_ALU, 4'd11, 5'd3, 32'h77, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("frozen_pop", 32'(commit_pop), 32'd0);
      checkOutput("frozen_commit_flag", 32'(commit_flag), 32'd0);
      endCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_ALU, 4'd11, 5'd3, 32'h77, 1'b0, 32'd0, 1'b0);
    pushExp(5'd3, 4'd11, 32'h77, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("thaw_pop", 32'(commit_pop), 32'd1);
    endCycle();
    idle(1'b0);
    @(negedge clk);
    checkOutput("thaw_commit_flag", 32'(commit_flag), 32'd1);
    checkOutput("thaw_retired_cnt", retired_cnt, 32'd7);
    endCycle();

    // Reset in the middle of WAIT_STORE; a frozen cycle keeps store_req up.
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_STORE, 4'd5, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    endCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, COMMIT_TYPE_STORE, 4'd5, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("frozen_store_pop", 32'(commit_pop), 32'd0);
    endCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_STORE, 4'd5, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("frozen_store_req", 32'(store_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_store_req", 32'(store_req), 32'd0);
    checkOutput("async_retired_cnt", retired_cnt, 32'd0);
    idle(1'b0);
    @(negedge clk) rst_n = 1'b1;
    endCycle();

    // Back in RUN; mispredict on an ALU entry is ignored, rd 0 still strobes.
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_ALU, 4'd12, 5'd4, 32'h99, 1'b1, 32'h300, 1'b0);
    pushExp(5'd4, 4'd12, 32'h99, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("post_rst_pop", 32'(commit_pop), 32'd1);
    checkOutput("post_rst_retired_cnt", retired_cnt, 32'd0);
    endCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_ALU, 4'd13, 5'd0, 32'hAA, 1'b0, 32'd0, 1'b0);
    pushExp(5'd0, 4'd13, 32'hAA, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("x0_pop", 32'(commit_pop), 32'd1);
    checkOutput("alu_mis_no_rollback", 32'(rollback_flag), 32'd0);
    endCycle();

    // HALT: one pop, then nothing more.
    applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_HALT, 4'd14, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput("halt_pop", 32'(commit_pop), 32'd1);
    endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, COMMIT_TYPE_ALU, 4'd15, 5'd8, 32'hBB, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      checkOutput("halted_pop", 32'(commit_pop), 32'd0);
      checkOutput("halt_out", 32'(halt_out), 32'd1);
      endCycle();
    end
    idle(1'b0);
    @(negedge clk);
    checkOutput("halt_retired_cnt", retired_cnt, 32'd3);
    checkOutput("halt_no_commit", 32'(commit_flag), 32'd0);
    endCycle();
    endCycle();
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
